// File: rtl/qnigma_chacha20_xor.sv
// ChaCha20 keystream XOR stage: fetches 512-bit blocks from the generator and XORs them onto a byte stream.
// Optional macro QNIGMA_CHACHA20_XOR_PREFETCH_EN adds a second block buffer so block boundaries do not stall.
module qnigma_chacha20_xor #(
  parameter logic [31:0] CTR_INIT = 32'h00000001
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ini,
  input  logic [7:0]   in_dat,
  input  logic         in_val,
  input  logic         in_lst,
  output logic         in_rdy,
  output logic [7:0]   out_dat,
  output logic         out_val,
  output logic         out_lst,
  input  logic         out_rdy,
  output logic         kst_req,
  input  logic         kst_val,
  input  logic [511:0] kst,
  output logic [31:0]  kst_bin,
  output logic         busy,
  output logic         err
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FETCH  = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;

  logic [1:0]   state_q, state_d;
  logic [5:0]   idx_q, idx_d;
  logic [511:0] blk_q, blk_d;
  logic [31:0]  kst_bin_q, kst_bin_d;
  logic         kst_req_q, kst_req_d;
  logic         out_val_q, out_val_d;
  logic         out_lst_q, out_lst_d;
  logic [7:0]   out_dat_q, out_dat_d;
  logic         busy_q, busy_d;
  logic         err_q, err_d;
`ifdef QNIGMA_CHACHA20_XOR_PREFETCH_EN
  logic [511:0] pf_blk_q, pf_blk_d;
  logic         pf_vld_q, pf_vld_d;
  logic         pf_pend_q, pf_pend_d;
  logic         pf_ready;
`endif

  logic [7:0] ks_byte;
  logic       hs;
  logic       bin_max;

  assign in_rdy  = (state_q == S_STREAM) && (!out_val_q || out_rdy);
  assign hs      = in_val && in_rdy;
  assign bin_max = (kst_bin_q == 32'hFFFFFFFF);

  assign out_dat = out_dat_q;
  assign out_val = out_val_q;
  assign out_lst = out_lst_q;
  assign kst_req = kst_req_q;
  assign kst_bin = kst_bin_q;
  assign busy    = busy_q;
  assign err     = err_q;

  // Little-endian serialisation: word k/4 sits at [511-32*(k/4) -: 32], byte k%4 is its low-order byte first.
  always_comb begin
    ks_byte = 8'h00;
    for (int k = 0; k < 64; k++) begin
      if (idx_q == 6'(k)) ks_byte = blk_q[480 - 32*(k/4) + 8*(k%4) +: 8];
    end
  end

`ifdef QNIGMA_CHACHA20_XOR_PREFETCH_EN
  assign pf_ready = pf_vld_q || (pf_pend_q && kst_val);
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    blk_d     = blk_q;
    kst_bin_d = kst_bin_q;
    kst_req_d = 1'b0;
    out_val_d = out_val_q;
    out_lst_d = out_lst_q;
    out_dat_d = out_dat_q;
    err_d     = err_q;
`ifdef QNIGMA_CHACHA20_XOR_PREFETCH_EN
    pf_blk_d  = pf_blk_q;
    pf_vld_d  = pf_vld_q;
    pf_pend_d = pf_pend_q;
`endif

    if (out_val_q && out_rdy) begin
      out_val_d = 1'b0;
      out_lst_d = 1'b0;
    end
    if (hs) begin
      out_val_d = 1'b1;
      out_dat_d = in_dat ^ ks_byte;
      out_lst_d = in_lst;
    end

    case (state_q)
      S_FETCH: begin
        if (kst_val) begin
          blk_d   = kst;
          idx_d   = 6'd0;
          state_d = S_STREAM;
`ifdef QNIGMA_CHACHA20_XOR_PREFETCH_EN
          pf_pend_d = 1'b0;
          if (!bin_max) begin
            kst_req_d = 1'b1;
            kst_bin_d = kst_bin_q + 32'd1;
            pf_pend_d = 1'b1;
          end
`endif
        end
      end
      S_STREAM: begin
`ifdef QNIGMA_CHACHA20_XOR_PREFETCH_EN
        if (kst_val && pf_pend_q) begin
          pf_blk_d  = kst;
          pf_vld_d  = 1'b1;
          pf_pend_d = 1'b0;
        end
`endif
        if (hs) begin
          idx_d = idx_q + 6'd1;
          if (in_lst) begin
            state_d = S_IDLE;
`ifdef QNIGMA_CHACHA20_XOR_PREFETCH_EN
            pf_vld_d  = 1'b0;
            pf_pend_d = 1'b0;
`endif
          end else if (idx_q == 6'd63) begin
`ifdef QNIGMA_CHACHA20_XOR_PREFETCH_EN
            // Swap straight in when the prefetch has landed (even this very cycle); else wait for it in FETCH.
            if (pf_ready) begin
              blk_d     = pf_vld_q ? pf_blk_q : kst;
              pf_vld_d  = 1'b0;
              pf_pend_d = 1'b0;
              if (!bin_max) begin
                kst_req_d = 1'b1;
                kst_bin_d = kst_bin_q + 32'd1;
                pf_pend_d = 1'b1;
              end
            end else if (pf_pend_q) begin
              state_d = S_FETCH;
            end else begin
              err_d   = 1'b1;
              state_d = S_IDLE;
            end
`else
            if (bin_max) begin
              err_d   = 1'b1;
              state_d = S_IDLE;
            end else begin
              kst_bin_d = kst_bin_q + 32'd1;
              kst_req_d = 1'b1;
              state_d   = S_FETCH;
            end
`endif
          end
        end
      end
      default: ;
    endcase

    // ini wins over everything, including a handshake in the same cycle.
    if (ini) begin
      state_d   = S_FETCH;
      idx_d     = 6'd0;
      kst_bin_d = CTR_INIT;
      kst_req_d = 1'b1;
      err_d     = 1'b0;
      out_val_d = 1'b0;
      out_lst_d = 1'b0;
      out_dat_d = 8'h00;
`ifdef QNIGMA_CHACHA20_XOR_PREFETCH_EN
      pf_vld_d  = 1'b0;
      pf_pend_d = 1'b0;
`endif
    end

    busy_d = (state_d != S_IDLE) || out_val_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= 6'd0;
      blk_q     <= '0;
      kst_bin_q <= CTR_INIT;
      kst_req_q <= 1'b0;
      out_val_q <= 1'b0;
      out_lst_q <= 1'b0;
      out_dat_q <= 8'h00;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      blk_q     <= blk_d;
      kst_bin_q <= kst_bin_d;
      kst_req_q <= kst_req_d;
      out_val_q <= out_val_d;
      out_lst_q <= out_lst_d;
      out_dat_q <= out_dat_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

`ifdef QNIGMA_CHACHA20_XOR_PREFETCH_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pf_blk_q  <= '0;
      pf_vld_q  <= 1'b0;
      pf_pend_q <= 1'b0;
    end else begin
      pf_blk_q  <= pf_blk_d;
      pf_vld_q  <= pf_vld_d;
      pf_pend_q <= pf_pend_d;
    end
  end
`endif

endmodule

// File: tb/tb_qnigma_chacha20_xor.sv
// Bench for qnigma_chacha20_xor: ChaCha20 block reference drives a keystream responder and predicts every output byte.
module tb_qnigma_chacha20_xor;

  logic clk, rst, ini, in_val, in_lst, out_rdy, sel;
  logic [7:0] in_dat;

  logic         in_rdy_w [2];
  logic [7:0]   out_dat_w [2];
  logic         out_val_w [2];
  logic         out_lst_w [2];
  logic         kst_req_w [2];
  logic         kst_val_w [2];
  logic [511:0] kst_w [2];
  logic [31:0]  kst_bin_w [2];
  logic         busy_w [2];
  logic         err_w [2];

  logic in_rdy_s, out_val_s, out_lst_s, kst_req_s, busy_s, err_s;
  logic [7:0]  out_dat_s;
  logic [31:0] kst_bin_s;

  qnigma_chacha20_xor u_a (
    .clk(clk), .rst(rst), .ini(ini && !sel), .in_dat(in_dat), .in_val(in_val && !sel),
    .in_lst(in_lst), .in_rdy(in_rdy_w[0]), .out_dat(out_dat_w[0]), .out_val(out_val_w[0]),
    .out_lst(out_lst_w[0]), .out_rdy(out_rdy), .kst_req(kst_req_w[0]), .kst_val(kst_val_w[0]),
    .kst(kst_w[0]), .kst_bin(kst_bin_w[0]), .busy(busy_w[0]), .err(err_w[0]));

  qnigma_chacha20_xor #(.CTR_INIT(32'hFFFFFFFF)) u_b (
    .clk(clk), .rst(rst), .ini(ini && sel), .in_dat(in_dat), .in_val(in_val && sel),
    .in_lst(in_lst), .in_rdy(in_rdy_w[1]), .out_dat(out_dat_w[1]), .out_val(out_val_w[1]),
    .out_lst(out_lst_w[1]), .out_rdy(out_rdy), .kst_req(kst_req_w[1]), .kst_val(kst_val_w[1]),
    .kst(kst_w[1]), .kst_bin(kst_bin_w[1]), .busy(busy_w[1]), .err(err_w[1]));

  always_comb begin
    in_rdy_s  = in_rdy_w[sel];
    out_val_s = out_val_w[sel];
    out_lst_s = out_lst_w[sel];
    out_dat_s = out_dat_w[sel];
    kst_req_s = kst_req_w[sel];
    kst_bin_s = kst_bin_w[sel];
    busy_s    = busy_w[sel];
    err_s     = err_w[sel];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int bp_viol = 0;
  logic bp_en = 1'b0;
  logic [7:0]  pt [0:255];
  logic [7:0]  out_q [$];
  logic        lst_q [$];
  logic [31:0] req_bins [$];

  typedef struct { int idx; logic [7:0] exp; } vec_t;
  vec_t rfc_tbl [7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // ---- ChaCha20 reference (key 00..1f, nonce 00000000 4a000000 00000000) ----
  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [127:0] qr(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] c, input logic [31:0] d);
    a += b; d ^= a; d = rotl(d, 16);
    c += d; b ^= c; b = rotl(b, 12);
    a += b; d ^= a; d = rotl(d, 8);
    c += d; b ^= c; b = rotl(b, 7);
    return {a, b, c, d};
  endfunction

  function automatic logic [511:0] chacha_blk(input logic [31:0] ctr);
    logic [31:0] s [16];
    logic [31:0] x [16];
    logic [511:0] r;
    s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) s[4+i] = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
    s[12] = ctr; s[13] = 32'h0; s[14] = 32'h4a000000; s[15] = 32'h0;
    x = s;
    for (int rd = 0; rd < 10; rd++) begin
      {x[0], x[4], x[8],  x[12]} = qr(x[0], x[4], x[8],  x[12]);
      {x[1], x[5], x[9],  x[13]} = qr(x[1], x[5], x[9],  x[13]);
      {x[2], x[6], x[10], x[14]} = qr(x[2], x[6], x[10], x[14]);
      {x[3], x[7], x[11], x[15]} = qr(x[3], x[7], x[11], x[15]);
      {x[0], x[5], x[10], x[15]} = qr(x[0], x[5], x[10], x[15]);
      {x[1], x[6], x[11], x[12]} = qr(x[1], x[6], x[11], x[12]);
      {x[2], x[7], x[8],  x[13]} = qr(x[2], x[7], x[8],  x[13]);
      {x[3], x[4], x[9],  x[14]} = qr(x[3], x[4], x[9],  x[14]);
    end
    r = '0;
    for (int i = 0; i < 16; i++) r[511 - 32*i -: 32] = x[i] + s[i];
    return r;
  endfunction

  // ---- keystream responder: answers each kst_req after a random delay ----
  initial begin
    logic        pend [2];
    int          cnt [2];
    logic [31:0] gbin [2];
    for (int j = 0; j < 2; j++) begin
      pend[j] = 1'b0; cnt[j] = 0; gbin[j] = '0; kst_val_w[j] = 1'b0; kst_w[j] = '0;
    end
    forever begin
      @(negedge clk);
      for (int j = 0; j < 2; j++) begin
        kst_val_w[j] = 1'b0;
        if (rst) pend[j] = 1'b0;
        if (pend[j]) begin
          if (cnt[j] == 0) begin
            kst_w[j] = chacha_blk(gbin[j]);
            kst_val_w[j] = 1'b1;
            pend[j] = 1'b0;
          end else cnt[j]--;
        end
        if (kst_req_w[j]) begin
          pend[j] = 1'b1;
          gbin[j] = kst_bin_w[j];
          cnt[j]  = $urandom_range(0, 3);
        end
      end
    end
  end

  // ---- output monitor ----
  always @(negedge clk) begin
    if (out_val_s && out_rdy) begin
      out_q.push_back(out_dat_s);
      lst_q.push_back(out_lst_s);
    end
    if (kst_req_s) req_bins.push_back(kst_bin_s);
    if (out_val_s && !out_rdy && in_rdy_s) bp_viol++;
  end

  always begin
    @(posedge clk); #1;
    if (bp_en) out_rdy = 1'($urandom_range(0, 1));
  end

  task automatic do_ini();
    ini = 1'b1;
    @(posedge clk); #1;
    ini = 1'b0;
    out_q.delete(); lst_q.delete(); req_bins.delete();
  endtask

  task automatic feed(input int n, input int lst_at, input int bound, output int acc);
    acc = 0;
    for (int i = 0; i < n; i++) begin
      int   w;
      logic hs;
      w = 0; hs = 1'b0;
      in_val = 1'b1; in_dat = pt[i]; in_lst = (i == lst_at);
      while (!hs && w < bound) begin
        @(negedge clk); hs = in_rdy_s;
        @(posedge clk); #1; w++;
      end
      if (!hs) break;
      acc++;
    end
    in_val = 1'b0; in_lst = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int w;
    w = 0;
    @(negedge clk);
    while (busy_s && w < 3000) begin @(negedge clk); w++; end
    chk({nm, "_idle"}, 64'(busy_s), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_stream(input string nm, input int n, input logic [31:0] ctr0,
                              input int exp_req, input int exp_nlst);
    logic [511:0] blk;
    logic [31:0]  w;
    int nl, lpos;
    blk = '0; nl = 0; lpos = -1;
    chk({nm, "_count"}, 64'(out_q.size()), 64'(n));
    for (int i = 0; i < n && i < out_q.size(); i++) begin
      if (i % 64 == 0) blk = chacha_blk(ctr0 + 32'(i / 64));
      w = blk[511 - 32*((i % 64) / 4) -: 32];
      chk($sformatf("%s_byte%0d", nm, i), 64'(out_q[i]), 64'(pt[i] ^ w[8*(i % 4) +: 8]));
    end
    foreach (lst_q[i]) if (lst_q[i]) begin nl++; lpos = i; end
    chk({nm, "_nlst"}, 64'(nl), 64'(exp_nlst));
    if (exp_nlst == 1) chk({nm, "_lstpos"}, 64'(lpos), 64'(n - 1));
    chk({nm, "_nreq"}, 64'(req_bins.size()), 64'(exp_req));
    foreach (req_bins[b]) chk($sformatf("%s_bin%0d", nm, b), 64'(req_bins[b]), 64'(ctr0 + 32'(b)));
  endtask

  function automatic int reqs_for(input int n);
    int r;
    r = (n + 63) / 64;
`ifdef QNIGMA_CHACHA20_XOR_PREFETCH_EN
    r++;
`endif
    return r;
  endfunction

  task automatic run_msg(input string nm, input int n, input logic start);
    int acc;
    if (start) do_ini();
    feed(n, n - 1, 2000, acc);
    chk({nm, "_acc"}, 64'(acc), 64'(n));
    wait_idle(nm);
    check_stream(nm, n, 32'd1, reqs_for(n), 1);
  endtask

  task automatic load_rfc();
    string s;
    s = "Ladies and Gentlemen of the class of '99: If I could offer you only one tip for the future, sunscreen would be it.";
    for (int i = 0; i < s.len(); i++) pt[i] = s[i];
  endtask

  initial begin
    int acc;
    rfc_tbl[0] = '{0, 8'h6e};   rfc_tbl[1] = '{1, 8'h2e};  rfc_tbl[2] = '{2, 8'h35};
    rfc_tbl[3] = '{3, 8'h9a};   rfc_tbl[4] = '{64, 8'h07}; rfc_tbl[5] = '{112, 8'h87};
    rfc_tbl[6] = '{113, 8'h4d};

    sel = 1'b0; rst = 1'b1; ini = 1'b0; in_val = 1'b0; in_lst = 1'b0; in_dat = 8'h00; out_rdy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_rdy",  64'(in_rdy_s),  64'd0);
    chk("rst_out_val", 64'(out_val_s), 64'd0);
    chk("rst_out_lst", 64'(out_lst_s), 64'd0);
    chk("rst_out_dat", 64'(out_dat_s), 64'd0);
    chk("rst_kst_req", 64'(kst_req_s), 64'd0);
    chk("rst_kst_bin", 64'(kst_bin_s), 64'd1);
    chk("rst_busy",    64'(busy_s),    64'd0);
    chk("rst_err",     64'(err_s),     64'd0);
    chk("rst_b_bin",   64'(kst_bin_w[1]), 64'hFFFFFFFF);
    @(posedge clk); #1; rst = 1'b0;

    // RFC 8439 2.4.2 clean run
    load_rfc();
    run_msg("rfc", 114, 1'b1);
    for (int i = 0; i < 7; i++)
      chk($sformatf("rfc_tbl%0d", rfc_tbl[i].idx), 64'(out_q[rfc_tbl[i].idx]), 64'(rfc_tbl[i].exp));

    // same vector under random backpressure
    bp_viol = 0; bp_en = 1'b1;
    run_msg("rfc_bp", 114, 1'b1);
    chk("bp_in_rdy", 64'(bp_viol), 64'd0);
    bp_en = 1'b0; out_rdy = 1'b1;

    // exactly one block, in_lst on byte 63
    for (int i = 0; i < 64; i++) pt[i] = 8'($urandom);
    run_msg("blk64", 64, 1'b1);

    // abort at byte 20: stale output held, ini coincides with a would-be handshake
    load_rfc();
    do_ini();
    feed(20, -1, 2000, acc);
    out_rdy = 1'b0; in_val = 1'b1; in_dat = pt[20];
    @(posedge clk); #1;
    out_rdy = 1'b1; ini = 1'b1;
    @(negedge clk);
    chk("abort_stale_pre", 64'(out_val_s), 64'd1);
    @(posedge clk); #1;
    ini = 1'b0; in_val = 1'b0;
    out_q.delete(); lst_q.delete(); req_bins.delete();
    @(negedge clk);
    chk("abort_out_val", 64'(out_val_s), 64'd0);
    @(posedge clk); #1;
    run_msg("abort", 114, 1'b0);

    // random lengths and payloads under backpressure
    for (int t = 0; t < 3; t++) begin
      int n;
      n = $urandom_range(1, 200);
      for (int i = 0; i < n; i++) pt[i] = 8'($urandom);
      bp_en = 1'b1;
      run_msg($sformatf("rnd%0d", t), n, 1'b1);
    end
    bp_en = 1'b0; out_rdy = 1'b1;

    // reset in the middle of a message
    do_ini();
    feed(10, -1, 2000, acc);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_busy",    64'(busy_s),    64'd0);
    chk("mrst_out_val", 64'(out_val_s), 64'd0);
    chk("mrst_in_rdy",  64'(in_rdy_s),  64'd0);
    chk("mrst_kst_bin", 64'(kst_bin_s), 64'd1);
    @(posedge clk); #1;

    // counter exhaustion on the CTR_INIT=FFFFFFFF instance
    sel = 1'b1;
    for (int i = 0; i < 65; i++) pt[i] = 8'($urandom);
    do_ini();
    feed(65, 64, 40, acc);
    chk("exh_acc", 64'(acc), 64'd64);
    wait_idle("exh");
    chk("exh_err",    64'(err_s),    64'd1);
    chk("exh_in_rdy", 64'(in_rdy_s), 64'd0);
    check_stream("exh", 64, 32'hFFFFFFFF, 1, 0);
    do_ini();
    @(negedge clk);
    chk("exh_err_clr", 64'(err_s), 64'd0);
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
